// File: rtl/layer_mac_scheduler.sv
// Time-multiplexed fully-connected layer controller: one shared signed 8x8 MAC
// sequenced over every output neuron, with ReLU/round/saturate requantisation.
module layer_mac_scheduler #(
    parameter int N_IN  = 15,
    parameter int N_OUT = 16,
    parameter int WA    = $clog2(N_IN * N_OUT),
    parameter int BA    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic [WA-1:0] w_addr,
    input  logic [7:0]    w_data,
    output logic [BA-1:0] b_addr,
    input  logic [15:0]   b_data,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic [BA-1:0] out_idx,
    input  logic          out_ready
);
    localparam int KW = $clog2(N_IN + 1);
    localparam logic [KW-1:0] L_CLAST = KW'(N_IN - 1);
    localparam logic [KW-1:0] L_CEND  = KW'(N_IN);
    localparam logic [KW-1:0] L_ONE   = KW'(1);
    localparam logic [BA-1:0] L_JLAST = BA'(N_OUT - 1);
    localparam logic [WA-1:0] L_NIN   = WA'(N_IN);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MAC, S_POST, S_OUT, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [KW-1:0]      r_c;
    logic [BA-1:0]      r_j;
    logic signed [22:0] r_acc;
    logic [7:0]         r_buf [N_IN];

    logic [KW-1:0]      w_bidx;
    logic signed [7:0]  w_act;
    logic signed [15:0] w_prod;
    logic signed [22:0] w_prod_x;
    logic signed [22:0] w_bias_x;
    logic [7:0]         w_q;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && r_c == L_CLAST) w_next = S_MAC;
            end
            S_MAC:  if (r_c == L_CEND) w_next = S_POST;
            S_POST: w_next = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = (r_j == L_JLAST) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // MAC cycle c consumes the weight addressed in cycle c-1
    assign w_bidx   = (r_c == '0) ? '0 : r_c - L_ONE;
    assign w_act    = r_buf[w_bidx];
    assign w_prod   = w_act * $signed(w_data);
    assign w_prod_x = {{7{w_prod[15]}}, w_prod};
    assign w_bias_x = {{7{b_data[15]}}, b_data};

    assign w_addr = (r_state == S_MAC) ? (WA'(r_j) * L_NIN + WA'(r_c)) : '0;
    assign b_addr = r_j;

    // Round carry may wrap 127+1 to 8'h80; the golden model expects that
    always_comb begin
        w_q = r_acc[13:6] + {7'b0, r_acc[5]};
        if (r_acc[22])          w_q = 8'd0;
        else if (|r_acc[21:13]) w_q = 8'd127;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && in_valid) r_buf[r_c] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c      <= '0;
            r_j      <= '0;
            r_acc    <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_c <= '0;
                    r_j <= '0;
                end
                S_LOAD: begin
                    if (in_valid) r_c <= (r_c == L_CLAST) ? '0 : r_c + L_ONE;
                end
                S_MAC: begin
                    if (r_c == L_ONE)    r_acc <= w_bias_x + w_prod_x;
                    else if (r_c != '0)  r_acc <= r_acc + w_prod_x;
                    r_c <= (r_c == L_CEND) ? '0 : r_c + L_ONE;
                end
                S_POST: begin
                    out_data <= w_q;
                    out_idx  <= r_j;
                end
                S_OUT: begin
                    if (out_ready && r_j != L_JLAST) r_j <= r_j + BA'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Directed testbench for layer_mac_scheduler with registered weight/bias
// memories and hand-computed requantised results (N_IN=15, N_OUT=2).
module tb_layer_mac_scheduler;
    localparam int N_IN  = 15;
    localparam int N_OUT = 2;
    localparam int WA    = $clog2(N_IN * N_OUT);
    localparam int BA    = 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [WA-1:0] w_addr;
    logic [7:0]    w_data;
    logic [BA-1:0] b_addr;
    logic [15:0]   b_data;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [BA-1:0] out_idx;
    logic          out_ready;

    logic [7:0]    w_mem [32];
    logic [15:0]   b_mem [2];
    logic [7:0]    act_v [N_IN];
    logic [7:0]    got_data [N_OUT];
    logic [BA-1:0] got_idx [N_OUT];

    int checks;
    int errors;
    bit timeout;
    bit done_seen;
    bit post_idle;
    bit bp_unstable;
    bit mon_en;
    bit busy_low;

    layer_mac_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data <= w_mem[w_addr];
        b_data <= b_mem[b_addr];
    end

    always @(negedge clk) begin
        if (mon_en && !busy) busy_low = 1'b1;
    end

    task automatic set_acts(input logic [7:0] v);
        for (int i = 0; i < N_IN; i++) act_v[i] = v;
    endtask

    task automatic set_w(input logic [7:0] v0, input logic [7:0] v1);
        for (int i = 0; i < N_IN; i++) begin
            w_mem[i]        = v0;
            w_mem[N_IN + i] = v1;
        end
    endtask

    // Drives one pass; stalls LOAD, back-pressures output 0, pokes start in MAC
    task automatic run_pass(input int stall_at, input int stall_len,
                            input int bp_len, input bit poke);
        int n;
        int cyc;
        int sl;
        sl = stall_len;
        timeout = 0; done_seen = 0; post_idle = 0;
        bp_unstable = 0; busy_low = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; mon_en = 1;
        n = 0; cyc = 0;
        while (n < N_IN && cyc < 200) begin
            if (n == stall_at && sl > 0) begin
                in_valid = 0; in_data = 8'h55;
                repeat (sl) @(negedge clk);
                cyc += sl; sl = 0;
            end
            in_valid = 1; in_data = act_v[n];
            if (in_ready) n++;
            @(negedge clk); cyc++;
        end
        in_valid = 0;
        if (n < N_IN) timeout = 1;
        if (poke) begin
            start = 1; @(negedge clk); start = 0;
        end
        for (int o = 0; o < N_OUT; o++) begin
            cyc = 0;
            while (!out_valid && cyc < 100) begin
                @(negedge clk); cyc++;
            end
            if (!out_valid) timeout = 1;
            got_data[o] = out_data;
            got_idx[o]  = out_idx;
            if (o == 0 && bp_len > 0) begin
                repeat (bp_len) begin
                    @(negedge clk);
                    if (!out_valid || out_data !== got_data[0] ||
                        out_idx !== got_idx[0] || b_addr !== got_idx[0])
                        bp_unstable = 1;
                end
            end
            out_ready = 1; @(negedge clk); out_ready = 0;
        end
        done_seen = (done === 1'b1);
        mon_en = 0;
        @(negedge clk);
        post_idle = (busy === 1'b0 && done === 1'b0);
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, in_ready, out_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 0000",
                     {busy, done, in_ready, out_valid});
        end
        checks++;
        if ({out_data, out_idx} !== '0) begin
            errors++;
            $display("FAIL reset_out: got data %0d idx %0d exp 0 0",
                     out_data, out_idx);
        end
        checks++;
        if ({w_addr, b_addr} !== '0) begin
            errors++;
            $display("FAIL reset_addr: got w %0d b %0d exp 0 0", w_addr, b_addr);
        end
        reset = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy got %b exp 0", busy);
        end
    endtask

    task automatic test_bias_only;
        set_acts(8'd0); set_w(8'd5, 8'd5);
        b_mem[0] = 16'd512; b_mem[1] = 16'd0;
        run_pass(-1, 0, 0, 0);
        checks++;
        if (got_data[0] !== 8'd8 || got_idx[0] !== 1'b0) begin
            errors++;
            $display("FAIL bias_out0: got (%0d,%0d) exp (0,8)",
                     got_idx[0], got_data[0]);
        end
        checks++;
        if (got_data[1] !== 8'd0 || got_idx[1] !== 1'b1) begin
            errors++;
            $display("FAIL bias_out1: got (%0d,%0d) exp (1,0)",
                     got_idx[1], got_data[1]);
        end
        checks++;
        if (timeout || !done_seen) begin
            errors++;
            $display("FAIL bias_done: timeout %b done %b exp 0 1",
                     timeout, done_seen);
        end
        checks++;
        if (busy_low) begin
            errors++;
            $display("FAIL bias_busy: busy dropped got 1 exp 0");
        end
        checks++;
        if (!post_idle) begin
            errors++;
            $display("FAIL bias_idle: got busy %b done %b exp 0 0", busy, done);
        end
    endtask

    task automatic test_round;
        set_acts(8'd10); set_w(8'd10, 8'd10);
        b_mem[0] = 16'd0; b_mem[1] = 16'd32;
        run_pass(-1, 0, 0, 0);
        checks++;
        if (got_data[0] !== 8'd23) begin
            errors++;
            $display("FAIL round_down: got %0d exp 23", got_data[0]);
        end
        checks++;
        if (got_data[1] !== 8'd24) begin
            errors++;
            $display("FAIL round_up: got %0d exp 24", got_data[1]);
        end
    endtask

    task automatic test_saturate_relu;
        set_acts(8'd127); set_w(8'd127, 8'hFF);
        b_mem[0] = 16'd0; b_mem[1] = 16'd0;
        run_pass(-1, 0, 0, 0);
        checks++;
        if (got_data[0] !== 8'd127) begin
            errors++;
            $display("FAIL saturate: got %0d exp 127", got_data[0]);
        end
        checks++;
        if (got_data[1] !== 8'd0) begin
            errors++;
            $display("FAIL relu_big: got %0d exp 0", got_data[1]);
        end
        set_acts(8'd1); set_w(8'hFF, 8'hFF);
        b_mem[0] = 16'd0; b_mem[1] = 16'd79;
        run_pass(-1, 0, 0, 0);
        checks++;
        if (got_data[0] !== 8'd0) begin
            errors++;
            $display("FAIL relu_small: got %0d exp 0", got_data[0]);
        end
        checks++;
        if (got_data[1] !== 8'd1) begin
            errors++;
            $display("FAIL neg_sum: got %0d exp 1", got_data[1]);
        end
    endtask

    task automatic test_wrap;
        set_acts(8'd0); set_w(8'd3, 8'd3);
        b_mem[0] = 16'd8160; b_mem[1] = 16'd8095;
        run_pass(-1, 0, 0, 0);
        checks++;
        if (got_data[0] !== 8'h80) begin
            errors++;
            $display("FAIL wrap: got %0h exp 80", got_data[0]);
        end
        checks++;
        if (got_data[1] !== 8'd126) begin
            errors++;
            $display("FAIL no_round: got %0d exp 126", got_data[1]);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < N_IN; i++) begin
            act_v[i]        = 8'(i + 1);
            w_mem[i]        = 8'(i + 1);
            w_mem[N_IN + i] = 8'd1;
        end
        b_mem[0] = 16'd0; b_mem[1] = 16'd2000;
        run_pass(7, 3, 5, 1);
        checks++;
        if (got_data[0] !== 8'd19) begin
            errors++;
            $display("FAIL stall_n0: got %0d exp 19", got_data[0]);
        end
        checks++;
        if (got_data[1] !== 8'd33 || got_idx[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_n1: got (%0d,%0d) exp (1,33)",
                     got_idx[1], got_data[1]);
        end
        checks++;
        if (bp_unstable) begin
            errors++;
            $display("FAIL backpressure: unstable got 1 exp 0");
        end
        checks++;
        if (timeout || !done_seen || !post_idle) begin
            errors++;
            $display("FAIL poke_done: timeout %b done %b idle %b exp 0 1 1",
                     timeout, done_seen, post_idle);
        end
    endtask

    task automatic test_reset_mid_mac;
        int cyc;
        bit stray;
        set_acts(8'd0); set_w(8'd5, 8'd5);
        b_mem[0] = 16'd512; b_mem[1] = 16'd0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; in_valid = 1; in_data = 8'd0;
        repeat (N_IN) @(negedge clk);
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        out_ready = 1; @(negedge clk); out_ready = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (b_addr !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mac1_reached: got b_addr %0d busy %b exp 1 1",
                     b_addr, busy);
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if ({busy, out_valid, done, in_ready} !== 4'b0) begin
            errors++;
            $display("FAIL abort_state: got %b exp 0000",
                     {busy, out_valid, done, in_ready});
        end
        reset = 0;
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || out_valid || busy) stray = 1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL abort_quiet: activity got 1 exp 0");
        end
        set_acts(8'd10); set_w(8'd10, 8'd10);
        b_mem[0] = 16'd0; b_mem[1] = 16'd32;
        run_pass(-1, 0, 0, 0);
        checks++;
        if (got_data[0] !== 8'd23 || got_data[1] !== 8'd24 || !done_seen) begin
            errors++;
            $display("FAIL fresh_pass: got %0d %0d done %b exp 23 24 1",
                     got_data[0], got_data[1], done_seen);
        end
    endtask

    initial begin
        clk = 0; reset = 1; start = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        checks = 0; errors = 0; mon_en = 0; busy_low = 0;
        for (int i = 0; i < 32; i++) w_mem[i] = 8'd0;
        b_mem[0] = 16'd0; b_mem[1] = 16'd0;
        test_reset;
        test_bias_only;
        test_round;
        test_saturate_relu;
        test_wrap;
        test_back_to_back;
        test_reset_mid_mac;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_mac_scheduler.md
Name: layer_mac_scheduler

Overview:
- Time-multiplexed controller for one fully-connected layer: a single shared signed 8x8 MAC replaces N_OUT parallel neuron nodes.
- Buffers the incoming activation vector, then sequences weight/bias memory reads and accumulation per output neuron.
- Applies the layer requantisation (ReLU, >>6 with round, saturate to 127) and streams results out.
- Sits between the previous layer's output stream and the next layer's input stream.

Parameters:
- N_IN, 15, activations per vector (inputs per neuron)
- N_OUT, 16, output neurons sequenced per vector
- WA, $clog2(N_IN*N_OUT), weight address width
- BA, $clog2(N_OUT) (min 1), bias address and output index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin one layer pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last output is accepted
- in_valid  in  1  activation valid
- in_data  in  8  activation, signed two's complement
- in_ready  out  1  high only in LOAD
- w_addr  out  WA  weight address = j*N_IN+k
- w_data  in  8  signed weight; valid one cycle after w_addr
- b_addr  out  BA  bias address = j
- b_data  in  16  signed bias; valid one cycle after b_addr
- out_valid  out  1  result valid
- out_data  out  8  requantised result (0..127, or 8'h80, see below)
- out_idx  out  BA  neuron index j of out_data
- out_ready  in  1  downstream accepts

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: state=IDLE; busy, done, in_ready and out_valid are 0; out_data, out_idx, w_addr and b_addr are 0; the accumulator and counters are cleared. Reset asserted in any state aborts the pass with no output or done. Buffer contents are don't-care after reset.
- IDLE:
  - start=1 -> LOAD with k=0.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1. Each cycle with in_valid=1 writes buf[k]=in_data and increments k.
  - When the write with k=N_IN-1 occurs -> MAC with j=0.
  - in_valid=0 stalls indefinitely; no timeout.
- MAC, N_IN+1 cycles per neuron:
  - Cycle c=0..N_IN-1 drives w_addr=j*N_IN+c. b_addr=j is held throughout MAC.
  - Cycle c=1 loads acc = sext23(b_data) + sext23(buf[0]*w_data).
  - Cycles c=2..N_IN add sext23(buf[c-1]*w_data).
  - The product is signed 8x8 -> 16 bits. The accumulator is 23-bit signed and does not overflow for N_IN<=127.
  - After c=N_IN -> POST.
- POST, 1 cycle, on acc:
  - acc[22]=1 -> 0.
  - Else acc[21:13]!=0 -> 127.
  - Else out_data = acc[13:6] + acc[5], computed in 8-bit arithmetic.
  - acc=8160..8191 therefore yields 8'h80. This bit-exact wrap is required to match the layer golden model.
  - Result and out_idx=j are registered; out_valid=1 -> OUT.
- OUT:
  - out_valid, out_data and out_idx are held stable until out_ready=1.
  - On the accept cycle: if j<N_OUT-1, then j++ -> MAC.
  - Otherwise -> DONE.
  - out_ready=1 already in the POST cycle has no effect; acceptance counts only while out_valid=1.
- DONE: done=1 for one cycle, busy=1 -> IDLE. A new start is accepted from IDLE on the next cycle.
- Throughput with no stalls: N_IN load cycles + N_OUT*(N_IN+3) cycles + 1.

Test Plan:
- N_IN=15, N_OUT=2, all activations 0, bias[0]=512, bias[1]=0:
  - expect out (idx0, 8) then (idx1, 0), then done one cycle after the second accept.
  - busy stays high from the cycle after start to the done cycle inclusive.
- Activations all 10, weights all 10, bias 0: acc=1500 -> out_data 23. Change to bias=32: acc=1532 -> 24, exercising the round bit.
- Activations all 127, weights all 127: acc=241935 -> 127 (saturation). Weights all -1, activations all 1, bias 0: acc=-15 -> 0 (ReLU).
- Activations all 0, bias=8160 -> out_data 8'h80 (wrap case). Bias=8095 -> 126, since 8095=126*64+31 and the round bit is 0.
- Backpressure and stalls:
  - Hold out_ready=0 for 5 cycles: out_data and out_idx stay stable and the next neuron does not start.
  - Stall in_valid mid-LOAD: k holds its value.
  - start pulsed while busy is ignored.
- Assert reset during MAC of neuron 1: the next cycle shows IDLE, busy=0, out_valid=0, and no done. A fresh start then completes a full pass correctly.
